// File: rtl/dmem_port.sv
// Byte-addressed little-endian data memory behind a valid/ready request/response port.
// Optional macro DMEM_FAULT_ADDR_EN adds the Fault_Addr output (address of the last faulting request).
module dmem_port #(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Req_Valid,
  output logic              Req_Ready,
  input  logic              Req_Write,
  input  logic [1:0]        Req_Size,
  input  logic              Req_Unsigned,
  input  logic [ADDR_W-1:0] Req_Addr,
  input  logic [31:0]       Req_Wdata,
  output logic              Rsp_Valid,
  input  logic              Rsp_Ready,
  output logic [31:0]       Rsp_Rdata,
  output logic              Rsp_Fault,
  output logic [1:0]        Rsp_Cause
`ifdef DMEM_FAULT_ADDR_EN
  ,
  output logic [ADDR_W-1:0] Fault_Addr
`endif
);

  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH_BYTES);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_ALIGN = 2'b01;
  localparam logic [1:0] CAUSE_RANGE = 2'b10;
  localparam logic [1:0] CAUSE_SIZE  = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t state_reg;

  logic             accept;
  logic [1:0]       size_m1;
  logic [ADDR_W:0]  last_addr;
  logic             misalign;
  logic             out_of_range;
  logic             req_fault;
  logic [1:0]       req_cause;
  logic [3:0]       lane_we;
  logic [31:0]      lane_wdata;
  logic             store_en;
  logic             load_en;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      rd_word;

  logic             rsp_load_reg;
  logic             rsp_fault_reg;
  logic [1:0]       rsp_cause_reg;
  logic [1:0]       rsp_size_reg;
  logic             rsp_unsigned_reg;
  logic [1:0]       rsp_off_reg;

  // A held response is consumed on the same edge a new request is taken.
  assign Req_Ready = (state_reg == IDLE) || Rsp_Ready;
  assign Rsp_Valid = (state_reg == RESP);
  assign accept    = Req_Valid && Req_Ready && !Rst;

  always_comb begin
    size_m1 = 2'd0;
    case (Req_Size)
      SIZE_HALF: size_m1 = 2'd1;
      SIZE_WORD: size_m1 = 2'd3;
      default:   size_m1 = 2'd0;
    endcase
  end

  // One extra bit so an access near the top of the address space cannot wrap.
  assign last_addr    = {1'b0, Req_Addr} + {{(ADDR_W-1){1'b0}}, size_m1};
  assign out_of_range = (last_addr >= DEPTH_LIM);
  assign misalign     = ((Req_Size == SIZE_HALF) && Req_Addr[0]) ||
                        ((Req_Size == SIZE_WORD) && (Req_Addr[1:0] != 2'b00));

  always_comb begin
    req_fault = 1'b1;
    req_cause = CAUSE_NONE;
    if (Req_Size == 2'b11) begin
      req_cause = CAUSE_SIZE;
    end else if (misalign) begin
      req_cause = CAUSE_ALIGN;
    end else if (out_of_range) begin
      req_cause = CAUSE_RANGE;
    end else begin
      req_fault = 1'b0;
    end
  end

  // Store data is replicated across lanes so each lane only needs its enable.
  always_comb begin
    lane_we    = 4'b0000;
    lane_wdata = Req_Wdata;
    case (Req_Size)
      SIZE_BYTE: begin
        lane_we    = 4'b0001 << Req_Addr[1:0];
        lane_wdata = {4{Req_Wdata[7:0]}};
      end
      SIZE_HALF: begin
        lane_we    = Req_Addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{Req_Wdata[15:0]}};
      end
      SIZE_WORD: begin
        lane_we    = 4'b1111;
        lane_wdata = Req_Wdata;
      end
      default: begin
        lane_we    = 4'b0000;
        lane_wdata = Req_Wdata;
      end
    endcase
  end

  assign store_en = accept && Req_Write && !req_fault;
  assign load_en  = accept && !Req_Write && !req_fault;
  assign word_idx = Req_Addr[IDX_W+1:2];

  // Four byte-wide RAM lanes with registered read; lane gi holds byte address 4*n+gi.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [WORDS];
      logic [7:0] rd_reg;

      always_ff @(posedge Clk) begin
        if (store_en && lane_we[gi]) begin
          mem[word_idx] <= lane_wdata[8*gi +: 8];
        end
        if (load_en) begin
          rd_reg <= mem[word_idx];
        end
      end

      assign rd_word[8*gi +: 8] = rd_reg;
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg        <= IDLE;
      rsp_load_reg     <= 1'b0;
      rsp_fault_reg    <= 1'b0;
      rsp_cause_reg    <= CAUSE_NONE;
      rsp_size_reg     <= SIZE_BYTE;
      rsp_unsigned_reg <= 1'b0;
      rsp_off_reg      <= 2'b00;
    end else begin
      if (accept) begin
        state_reg        <= RESP;
        rsp_load_reg     <= !Req_Write && !req_fault;
        rsp_fault_reg    <= req_fault;
        rsp_cause_reg    <= req_cause;
        rsp_size_reg     <= Req_Size;
        rsp_unsigned_reg <= Req_Unsigned;
        rsp_off_reg      <= Req_Addr[1:0];
      end else if (Rsp_Ready) begin
        state_reg <= IDLE;
      end
    end
  end

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  assign shifted  = rd_word >> {rsp_off_reg, 3'b000};
  assign byte_sel = shifted[7:0];
  assign half_sel = rsp_off_reg[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data = rd_word;
    case (rsp_size_reg)
      SIZE_BYTE: load_data = {{24{!rsp_unsigned_reg && byte_sel[7]}}, byte_sel};
      SIZE_HALF: load_data = {{16{!rsp_unsigned_reg && half_sel[15]}}, half_sel};
      default:   load_data = rd_word;
    endcase
  end

  assign Rsp_Rdata = ((state_reg == RESP) && rsp_load_reg) ? load_data : 32'h0;
  assign Rsp_Fault = rsp_fault_reg;
  assign Rsp_Cause = rsp_cause_reg;

`ifdef DMEM_FAULT_ADDR_EN
  logic [ADDR_W-1:0] fault_addr_reg;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      fault_addr_reg <= '0;
    end else if (accept && req_fault) begin
      fault_addr_reg <= Req_Addr;
    end
  end

  assign Fault_Addr = fault_addr_reg;
`endif

endmodule

// File: tb/tb_dmem_port.sv
// Directed bench for dmem_port: loads/stores, extension, faults, back-pressure and reset.
module tb_dmem_port;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Req_Valid;
  logic        Req_Ready;
  logic        Req_Write;
  logic [1:0]  Req_Size;
  logic        Req_Unsigned;
  logic [31:0] Req_Addr;
  logic [31:0] Req_Wdata;
  logic        Rsp_Valid;
  logic        Rsp_Ready;
  logic [31:0] Rsp_Rdata;
  logic        Rsp_Fault;
  logic [1:0]  Rsp_Cause;
`ifdef DMEM_FAULT_ADDR_EN
  logic [31:0] Fault_Addr;
`endif

  int vectors    = 0;
  int miscompares = 0;

  dmem_port #(.DEPTH_BYTES(1024), .ADDR_W(32)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Req_Valid    (Req_Valid),
    .Req_Ready    (Req_Ready),
    .Req_Write    (Req_Write),
    .Req_Size     (Req_Size),
    .Req_Unsigned (Req_Unsigned),
    .Req_Addr     (Req_Addr),
    .Req_Wdata    (Req_Wdata),
    .Rsp_Valid    (Rsp_Valid),
    .Rsp_Ready    (Rsp_Ready),
    .Rsp_Rdata    (Rsp_Rdata),
    .Rsp_Fault    (Rsp_Fault),
    .Rsp_Cause    (Rsp_Cause)
`ifdef DMEM_FAULT_ADDR_EN
    ,
    .Fault_Addr   (Fault_Addr)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input logic [31:0] rdata,
                           input logic fault, input logic [1:0] cause);
    check({tag, ".valid"}, 32'(Rsp_Valid), 32'h1);
    check({tag, ".rdata"}, Rsp_Rdata, rdata);
    check({tag, ".fault"}, 32'(Rsp_Fault), 32'(fault));
    check({tag, ".cause"}, 32'(Rsp_Cause), 32'(cause));
  endtask

  task automatic drive(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    Req_Valid    = 1'b1;
    Req_Write    = w;
    Req_Size     = sz;
    Req_Unsigned = u;
    Req_Addr     = a;
    Req_Wdata    = d;
  endtask

  // One accepted request; returns #1 after the accepting edge with the response visible.
  task automatic xfer(input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] d);
    drive(w, sz, u, a, d);
    @(posedge Clk);
    #1;
    Req_Valid = 1'b0;
    $display("txn %s size=%0d uns=%0d addr=%h wdata=%h -> valid=%0d rdata=%h fault=%0d cause=%0d",
             w ? "st" : "ld", sz, u, a, d, Rsp_Valid, Rsp_Rdata, Rsp_Fault, Rsp_Cause);
  endtask

  initial begin
    Rst = 1'b1;
    Rsp_Ready = 1'b1;
    Req_Valid = 1'b0;
    Req_Write = 1'b0;
    Req_Size = 2'b00;
    Req_Unsigned = 1'b0;
    Req_Addr = 32'h0;
    Req_Wdata = 32'h0;

    repeat (2) @(posedge Clk);
    #1;
    check("rst.valid", 32'(Rsp_Valid), 32'h0);
    check("rst.rdata", Rsp_Rdata, 32'h0);
    check("rst.fault", 32'(Rsp_Fault), 32'h0);
    check("rst.cause", 32'(Rsp_Cause), 32'h0);
`ifdef DMEM_FAULT_ADDR_EN
    check("rst.faddr", Fault_Addr, 32'h0);
`endif
    Rst = 1'b0;
    Rsp_Ready = 1'b0;
    #1;
    check("post_rst.req_ready", 32'(Req_Ready), 32'h1);
    Rsp_Ready = 1'b1;

    // Word store/load and sub-word extension
    xfer(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    check_rsp("sw10", 32'h0, 1'b0, 2'b00);
    xfer(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check_rsp("lw10", 32'hDEADBEEF, 1'b0, 2'b00);
    xfer(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    check_rsp("lb13", 32'hFFFFFFDE, 1'b0, 2'b00);
    xfer(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    check_rsp("lbu13", 32'h000000DE, 1'b0, 2'b00);
    xfer(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    check_rsp("lh12", 32'hFFFFDEAD, 1'b0, 2'b00);
    xfer(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
    check_rsp("lhu10", 32'h0000BEEF, 1'b0, 2'b00);
    xfer(1'b0, 2'b10, 1'b1, 32'h10, 32'h0);
    check_rsp("lw10_uns", 32'hDEADBEEF, 1'b0, 2'b00);

    // Faulted store leaves memory alone
    xfer(1'b1, 2'b10, 1'b0, 32'h12, 32'h12345678);
    check_rsp("sw12_misalign", 32'h0, 1'b1, 2'b01);
`ifdef DMEM_FAULT_ADDR_EN
    check("sw12.faddr", Fault_Addr, 32'h12);
`endif
    xfer(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check_rsp("lw10_after_fault", 32'hDEADBEEF, 1'b0, 2'b00);

    // Byte and half stores touch only their lanes
    xfer(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFFA5);
    check_rsp("sb11", 32'h0, 1'b0, 2'b00);
    xfer(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check_rsp("lw10_sb", 32'hDEADA5EF, 1'b0, 2'b00);
    xfer(1'b1, 2'b01, 1'b0, 32'h12, 32'hCAFE1234);
    check_rsp("sh12", 32'h0, 1'b0, 2'b00);
    xfer(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check_rsp("lw10_sh", 32'h1234A5EF, 1'b0, 2'b00);
    xfer(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    check_rsp("lb11", 32'hFFFFFFA5, 1'b0, 2'b00);

    // Fault classes, priority and the top-of-memory boundary
    xfer(1'b0, 2'b10, 1'b0, 32'h3FE, 32'h0);
    check_rsp("lw3fe", 32'h0, 1'b1, 2'b01);
    xfer(1'b0, 2'b01, 1'b0, 32'h400, 32'h0);
    check_rsp("lh400", 32'h0, 1'b1, 2'b10);
`ifdef DMEM_FAULT_ADDR_EN
    check("lh400.faddr", Fault_Addr, 32'h400);
`endif
    xfer(1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    check_rsp("size11_0", 32'h0, 1'b1, 2'b11);
    xfer(1'b0, 2'b11, 1'b0, 32'h401, 32'h0);
    check_rsp("size11_401", 32'h0, 1'b1, 2'b11);
    xfer(1'b0, 2'b10, 1'b0, 32'h402, 32'h0);
    check_rsp("lw402", 32'h0, 1'b1, 2'b01);
    xfer(1'b1, 2'b00, 1'b0, 32'h3FF, 32'h00000080);
    check_rsp("sb3ff", 32'h0, 1'b0, 2'b00);
    xfer(1'b0, 2'b00, 1'b0, 32'h3FF, 32'h0);
    check_rsp("lb3ff", 32'hFFFFFF80, 1'b0, 2'b00);
    xfer(1'b0, 2'b00, 1'b1, 32'h3FF, 32'h0);
    check_rsp("lbu3ff", 32'h00000080, 1'b0, 2'b00);
    xfer(1'b1, 2'b10, 1'b0, 32'h3FC, 32'h00000000);
    check_rsp("sw3fc", 32'h0, 1'b0, 2'b00);
    xfer(1'b1, 2'b01, 1'b0, 32'h3FE, 32'h0000F00D);
    check_rsp("sh3fe", 32'h0, 1'b0, 2'b00);
    xfer(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0);
    check_rsp("lw3fc", 32'hF00D0000, 1'b0, 2'b00);
    xfer(1'b1, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h0);
    check_rsp("sw_top", 32'h0, 1'b1, 2'b10);

    // Back-pressure: four loads with the response side stalled
    xfer(1'b1, 2'b10, 1'b0, 32'h20, 32'h0A0A0001);
    xfer(1'b1, 2'b10, 1'b0, 32'h24, 32'h0B0B0002);
    xfer(1'b1, 2'b10, 1'b0, 32'h28, 32'h0C0C0003);
    xfer(1'b1, 2'b10, 1'b0, 32'h2C, 32'h0D0D0004);
    @(posedge Clk);
    #1;
    Rsp_Ready = 1'b0;
    drive(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    @(posedge Clk);
    #1;
    $display("txn ld addr=00000020 stalled -> valid=%0d rdata=%h", Rsp_Valid, Rsp_Rdata);
    check_rsp("bp0", 32'h0A0A0001, 1'b0, 2'b00);
    drive(1'b0, 2'b10, 1'b0, 32'h24, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("bp_stall.req_ready", 32'(Req_Ready), 32'h0);
      @(posedge Clk);
      #1;
      check_rsp("bp0_hold", 32'h0A0A0001, 1'b0, 2'b00);
    end
    Rsp_Ready = 1'b1;
    #1;
    check("bp_release.req_ready", 32'(Req_Ready), 32'h1);
    @(posedge Clk);
    #1;
    $display("txn ld addr=00000024 -> valid=%0d rdata=%h", Rsp_Valid, Rsp_Rdata);
    check_rsp("bp1", 32'h0B0B0002, 1'b0, 2'b00);
    drive(1'b0, 2'b10, 1'b0, 32'h28, 32'h0);
    @(posedge Clk);
    #1;
    $display("txn ld addr=00000028 -> valid=%0d rdata=%h", Rsp_Valid, Rsp_Rdata);
    check_rsp("bp2", 32'h0C0C0003, 1'b0, 2'b00);
    drive(1'b0, 2'b10, 1'b0, 32'h2C, 32'h0);
    @(posedge Clk);
    #1;
    $display("txn ld addr=0000002c -> valid=%0d rdata=%h", Rsp_Valid, Rsp_Rdata);
    check_rsp("bp3", 32'h0D0D0004, 1'b0, 2'b00);
    Req_Valid = 1'b0;
    @(posedge Clk);
    #1;
    check("bp_drain.valid", 32'(Rsp_Valid), 32'h0);

    // Reset while a response is held and a store is offered
    xfer(1'b1, 2'b10, 1'b0, 32'h30, 32'h11111111);
    xfer(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    check_rsp("lw30_pre", 32'h11111111, 1'b0, 2'b00);
    drive(1'b1, 2'b10, 1'b0, 32'h30, 32'h22222222);
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    $display("txn st addr=00000030 under reset -> valid=%0d rdata=%h", Rsp_Valid, Rsp_Rdata);
    check("midrst.valid", 32'(Rsp_Valid), 32'h0);
    check("midrst.rdata", Rsp_Rdata, 32'h0);
    Rst = 1'b0;
    Req_Valid = 1'b0;
    Rsp_Ready = 1'b0;
    #1;
    check("midrst.req_ready", 32'(Req_Ready), 32'h1);
    Rsp_Ready = 1'b1;
    xfer(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    check_rsp("lw30_post", 32'h11111111, 1'b0, 2'b00);
    xfer(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check_rsp("lw10_post", 32'h1234A5EF, 1'b0, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_port.md
DMEM_PORT -- requirements
Module: dmem_port

Interface
REQ-001 SHALL have parameter DEPTH_BYTES, default 1024, byte capacity; power of two, >= 4.
REQ-002 SHALL have parameter ADDR_W, default 32, request address width.
REQ-003 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port Rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Req_Valid  input  1  request present.
REQ-006 SHALL have port Req_Ready  output  1  request accepted when Req_Valid && Req_Ready at a rising edge.
REQ-007 SHALL have port Req_Write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port Req_Size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-009 SHALL have port Req_Unsigned  input  1  load extension: 0 sign, 1 zero.
REQ-010 SHALL have port Req_Addr  input  ADDR_W  byte address.
REQ-011 SHALL have port Req_Wdata  input  32  store data, low-order bytes used.
REQ-012 SHALL have port Rsp_Valid  output  1  response present.
REQ-013 SHALL have port Rsp_Ready  input  1  response consumed when Rsp_Valid && Rsp_Ready at a rising edge.
REQ-014 SHALL have port Rsp_Rdata  output  32  extended load data; 0 for stores and faults.
REQ-015 SHALL have port Rsp_Fault  output  1  request faulted, no memory effect.
REQ-016 SHALL have port Rsp_Cause  output  2  00 none, 01 misaligned, 10 out of range, 11 reserved size.

Function
REQ-017 SHALL store data as DEPTH_BYTES bytes, little-endian, byte-addressed.
REQ-018 SHALL implement FSM states IDLE (no response held) and RESP (response held); IDLE->RESP on accept; RESP->IDLE on consume without new accept; RESP->RESP on consume with same-edge accept.
REQ-019 SHALL drive Req_Ready = (state==IDLE) || Rsp_Ready, combinationally; Rsp_Valid = (state==RESP).
REQ-020 SHALL produce response exactly one cycle after acceptance (registered), giving one request per cycle under Rsp_Ready=1.
REQ-021 SHALL hold Rsp_Rdata/Rsp_Fault/Rsp_Cause stable while Rsp_Valid && !Rsp_Ready.
REQ-022 SHALL fault misaligned: half with Addr[0]=1, word with Addr[1:0]!=00; Cause 01.
REQ-023 SHALL fault out-of-range: Req_Addr + size_bytes - 1 >= DEPTH_BYTES; Cause 10.
REQ-024 SHALL fault Req_Size=11 with Cause 11; priority reserved size > misaligned > out of range.
REQ-025 SHALL commit store bytes at the accepting edge only when not faulted; byte writes 1, half 2, word 4 bytes.
REQ-026 SHALL sample load bytes at the accepting edge; load accepted same edge as a store already committed observes the new data (write-then-read order across edges; no same-edge hazard possible).
REQ-027 SHALL sign- or zero-extend byte/half loads per Req_Unsigned; word loads unaffected.
REQ-028 SHALL return Rsp_Rdata = 0 for stores and all faults.

Reset
REQ-029 SHALL, while Rst=1, force state IDLE, Rsp_Valid=0, Rsp_Rdata=0, Rsp_Fault=0, Rsp_Cause=00, and accept nothing (no memory write even if Req_Valid=1).
REQ-030 SHALL discard any held response on reset mid-operation; memory contents SHALL NOT be reset.
REQ-031 SHALL present Req_Ready=1 in the first cycle after Rst deasserts.

Configuration
REQ-032 SHALL, with macro DMEM_FAULT_ADDR_EN defined, add output Fault_Addr (ADDR_W) capturing Req_Addr of each accepted faulting request, reset 0, held until next fault.
REQ-033 SHALL, without DMEM_FAULT_ADDR_EN, omit Fault_Addr; all other behaviour identical.

Verification
REQ-034 SHALL test: store word 0xDEADBEEF @0x10, load word @0x10 -> Rdata 0xDEADBEEF, Fault 0, one cycle after accept.
REQ-035 SHALL test: after REQ-034, load byte signed @0x13 -> 0xFFFFFFDE; byte unsigned @0x13 -> 0x000000DE; half signed @0x12 -> 0xFFFFDEAD.
REQ-036 SHALL test: store word @0x12 -> Fault 1, Cause 01, memory @0x10..0x13 unchanged; with macro, Fault_Addr=0x12.
REQ-037 SHALL test: load word @0x3FE (DEPTH_BYTES=1024) -> Cause 01; load half @0x400 -> Cause 10, Rdata 0; Size=11 @0x0 -> Cause 11.
REQ-038 SHALL test: 4 back-to-back loads with Rsp_Ready=0 for 3 cycles -> Req_Ready=0, first response held stable, then 4 responses in order on consecutive cycles.
REQ-039 SHALL test: Rst asserted while Rsp_Valid=1 and a store presented -> Rsp_Valid=0 next cycle, store not committed, prior memory data readable after reset.
